io_port_pcint: RTL and testbench
================================

Name: io_port_pcint

Overview:
- Parametrised general-purpose I/O port. Successor to the fixed-width port wrappers: 1–8 pins, per-pin alternate-function override buses, and an internal multi-stage input synchroniser.
- Adds PINx write-toggle of PORTx, a pin-change mask register, pin-change edge detection, a sticky flag and an interrupt request.
- Sits on the 6-bit I/O address bus beside the other port blocks and feeds the pad ring and the interrupt controller.

Parameters:
- WIDTH, 8, number of pins (1..8); unused data-bus bits read 0 and are ignored on write.
- PIN_ADDR, 6'h03, PINx I/O address.
- DDR_ADDR, 6'h04, DDRx I/O address.
- PORT_ADDR, 6'h05, PORTx I/O address.
- PCMSK_ADDR, 6'h2B, pin-change mask register address.
- PCIFR_ADDR, 6'h1B, shared pin-change flag register address.
- PCIF_BIT, 0, bit of PCIFR owned by this port.
- SYNC_STAGES, 2, input synchroniser depth (2..3).

Ports:
- cp2  in  1  clock
- ireset  in  1  asynchronous active-high reset
- IO_Addr  in  6  I/O address
- iore  in  1  I/O read strobe
- iowe  in  1  I/O write strobe
- dbus_in  in  8  write data
- dbus_out  out  8  read data
- out_en  out  1  read-data valid / bus drive enable
- pin_i  in  WIDTH  raw pad inputs
- PUD  in  1  global pull-up disable
- SLEEP  in  1  sleep-mode input disable
- pcie  in  1  pin-change interrupt enable for this port
- pcif_ack  in  1  interrupt-acknowledge pulse, clears flag
- ovr_pu_oe, ovr_pu_ov, ovr_dd_oe, ovr_dd_ov, ovr_pv_oe, ovr_pv_ov, ovr_die_oe, ovr_die_ov  in  WIDTH each  alternate-function override enables/values
- pu_n_o  out  WIDTH  pull-up enable, active low
- dd_o  out  WIDTH  pad output enable
- pv_o  out  WIDTH  pad output value
- die_o  out  WIDTH  digital-input disable, active high
- din_o  out  WIDTH  synchronised pin values to peripherals
- pcif  out  1  pin-change flag
- irq  out  1  pin-change interrupt request

Behaviour:
- One clock (cp2). Reset is asynchronous and active-high (ireset). All flops use this single clock and reset.
- Reset state: PORTx = 0, DDRx = 0, PCMSK = 0, all synchroniser stages = 0, prev = 0, pcif = 0.
- Writes (iowe, on the cp2 edge):
  - DDR_ADDR loads DDRx.
  - PORT_ADDR loads PORTx.
  - PCMSK_ADDR loads PCMSK.
  - PIN_ADDR toggles every PORTx bit whose dbus_in bit is 1.
  - PCIFR_ADDR with dbus_in[PCIF_BIT] = 1 clears pcif (write-1-to-clear). Other PCIFR bits are ignored.
- Reads: out_en = iore AND IO_Addr matches any of the five addresses. dbus_out is combinational and is 0 when out_en = 0.
  - PIN_ADDR returns din_o; the other addresses return their register.
  - PCIFR_ADDR returns pcif on PCIF_BIT and 0 elsewhere.
- Qualified input: q = pin_i AND NOT die_o, passed through SYNC_STAGES flops. din_o is the last stage.
  - A pad change is visible on din_o and PINx exactly SYNC_STAGES edges later.
- prev register holds din_o delayed by one cycle.
  - chg = (din_o XOR prev) AND PCMSK.
  - If pcie = 1 and chg is non-zero, pcif sets on the next edge.
  - A pin change detected while pcie = 0 is discarded, not remembered.
- pcif clears on pcif_ack or a PCIFR write-1. A set on the same edge as a clear wins (pcif stays 1).
- irq = pcif AND pcie (combinational).
- Per-pin output logic, bit n:
  - pu = ovr_pu_oe ? ovr_pu_ov : (PORTx AND NOT DDRx AND NOT PUD); pu_n_o = NOT pu.
  - dd_o = ovr_dd_oe ? ovr_dd_ov : DDRx.
  - pv_o = ovr_pv_oe ? ovr_pv_ov : PORTx.
  - die_o = ovr_die_oe ? ovr_die_ov : ((PCMSK AND pcie) ? 0 : SLEEP).
- Masked pin-change pins stay input-enabled in sleep so they can wake the device.
- Reset mid-operation: a change in flight in the synchroniser is lost and no flag is raised after reset release.
- Clearing a PCMSK bit suppresses an edge already in prev/din_o on the next cycle.

Test Plan:
- Reset, then read PORT/DDR/PCMSK/PIN/PCIFR -> all 0x00, out_en high on each read, dbus_out 0 when iore = 0.
- Write PORTx = 0xA5, then PINx = 0x0F -> PORTx reads 0xAA, pv_o = 0xAA; DDRx = 0xF0 -> dd_o = 0xF0, pu_n_o = 0xF5; PUD = 1 -> pu_n_o = 0xFF.
- pin_i bit 3 rises with SYNC_STAGES = 2 -> PINx bit 3 reads 1 after exactly 2 edges; with SLEEP = 1 and no mask, din_o stays 0.
- PCMSK = 0x08, pcie = 1, toggle pin 3 -> pcif = 1 and irq = 1 at edge 3; toggle pin 2 (unmasked) -> no flag; pcie = 0 and toggle -> no flag.
- pcif set, then same-cycle new change and PCIFR write 0x01 -> pcif stays 1; next write 0x01 alone -> pcif 0; pcif_ack pulse also clears.
- Overrides: ovr_dd_oe = 0xFF, ovr_dd_ov = 0, ovr_pv_oe = 0x01, ovr_pv_ov = 0x01 -> dd_o = 0x00, pv_o bit 0 = 1; assert ireset mid-synchronisation -> pcif 0, din_o 0.

Source files
------------

// File: rtl/io_port_pcint_if.sv
// I/O-bus bundle shared by the port blocks: 6-bit address, read/write strobes,
// write data towards the port and read data / drive enable back from it.
interface io_port_pcint_if;
    logic [5:0] IO_Addr;
    logic       iore;
    logic       iowe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;

    modport master (output IO_Addr, iore, iowe, dbus_in, input dbus_out, out_en);
    modport slave  (input IO_Addr, iore, iowe, dbus_in, output dbus_out, out_en);
endinterface

// File: rtl/io_port_pcint.sv
// Parametrised GPIO port: PORT/DDR/PIN registers, alternate-function overrides,
// input synchroniser and a pin-change flag with interrupt request.
module io_port_pcint #(
    parameter int         WIDTH       = 8,
    parameter logic [5:0] PIN_ADDR    = 6'h03,
    parameter logic [5:0] DDR_ADDR    = 6'h04,
    parameter logic [5:0] PORT_ADDR   = 6'h05,
    parameter logic [5:0] PCMSK_ADDR  = 6'h2B,
    parameter logic [5:0] PCIFR_ADDR  = 6'h1B,
    parameter int         PCIF_BIT    = 0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             cp2,
    input  logic             ireset,
    io_port_pcint_if.slave   bus,
    input  logic [WIDTH-1:0] pin_i,
    input  logic             PUD,
    input  logic             SLEEP,
    input  logic             pcie,
    input  logic             pcif_ack,
    input  logic [WIDTH-1:0] ovr_pu_oe,
    input  logic [WIDTH-1:0] ovr_pu_ov,
    input  logic [WIDTH-1:0] ovr_dd_oe,
    input  logic [WIDTH-1:0] ovr_dd_ov,
    input  logic [WIDTH-1:0] ovr_pv_oe,
    input  logic [WIDTH-1:0] ovr_pv_ov,
    input  logic [WIDTH-1:0] ovr_die_oe,
    input  logic [WIDTH-1:0] ovr_die_ov,
    output logic [WIDTH-1:0] pu_n_o,
    output logic [WIDTH-1:0] dd_o,
    output logic [WIDTH-1:0] pv_o,
    output logic [WIDTH-1:0] die_o,
    output logic [WIDTH-1:0] din_o,
    output logic             pcif,
    output logic             irq
);
    logic [WIDTH-1:0]                  port_q, port_d;
    logic [WIDTH-1:0]                  ddr_q, ddr_d;
    logic [WIDTH-1:0]                  pcmsk_q, pcmsk_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic                              pcif_q, pcif_d;

    logic [WIDTH-1:0] wdata_s, pu_s, qual_s, chg_s;
    logic [7:0]       rdata_s;
    logic             rd_hit_s;
    logic             wr_pin_s, wr_ddr_s, wr_port_s, wr_pcmsk_s, wr_pcifr_s;
    logic             pcif_set_s, pcif_clr_s;

    assign wdata_s    = bus.dbus_in[WIDTH-1:0];
    assign wr_pin_s   = bus.iowe && (bus.IO_Addr == PIN_ADDR);
    assign wr_ddr_s   = bus.iowe && (bus.IO_Addr == DDR_ADDR);
    assign wr_port_s  = bus.iowe && (bus.IO_Addr == PORT_ADDR);
    assign wr_pcmsk_s = bus.iowe && (bus.IO_Addr == PCMSK_ADDR);
    assign wr_pcifr_s = bus.iowe && (bus.IO_Addr == PCIFR_ADDR);

    // Pad controls; masked pin-change pins keep their input buffer alive in sleep
    assign pu_s   = (ovr_pu_oe & ovr_pu_ov) | (~ovr_pu_oe & port_q & ~ddr_q & {WIDTH{~PUD}});
    assign pu_n_o = ~pu_s;
    assign dd_o   = (ovr_dd_oe & ovr_dd_ov) | (~ovr_dd_oe & ddr_q);
    assign pv_o   = (ovr_pv_oe & ovr_pv_ov) | (~ovr_pv_oe & port_q);
    assign die_o  = (ovr_die_oe & ovr_die_ov)
                  | (~ovr_die_oe & ~(pcmsk_q & {WIDTH{pcie}}) & {WIDTH{SLEEP}});

    assign qual_s = pin_i & ~die_o;
    assign sync_d = {sync_q[SYNC_STAGES-2:0], qual_s};
    assign din_o  = sync_q[SYNC_STAGES-1];

    assign chg_s      = (din_o ^ prev_q) & pcmsk_q;
    assign pcif_set_s = pcie && (|chg_s);
    assign pcif_clr_s = pcif_ack || (wr_pcifr_s && bus.dbus_in[PCIF_BIT]);
    assign pcif       = pcif_q;
    assign irq        = pcif_q & pcie;

    // Register next-state: plain loads, PIN write toggles PORT bits
    always_comb begin
        port_d  = port_q;
        ddr_d   = ddr_q;
        pcmsk_d = pcmsk_q;
        if (wr_port_s) begin
            port_d = wdata_s;
        end else if (wr_pin_s) begin
            port_d = port_q ^ wdata_s;
        end else begin
            port_d = port_q;
        end
        if (wr_ddr_s) begin
            ddr_d = wdata_s;
        end else begin
            ddr_d = ddr_q;
        end
        if (wr_pcmsk_s) begin
            pcmsk_d = wdata_s;
        end else begin
            pcmsk_d = pcmsk_q;
        end
    end

    // Flag next-state: a new change on the clearing edge keeps the flag set
    always_comb begin
        pcif_d = pcif_q;
        if (pcif_set_s) begin
            pcif_d = 1'b1;
        end else if (pcif_clr_s) begin
            pcif_d = 1'b0;
        end else begin
            pcif_d = pcif_q;
        end
    end

    // Read-back mux, zero outside the decoded addresses
    always_comb begin
        rdata_s  = 8'h00;
        rd_hit_s = 1'b1;
        case (bus.IO_Addr)
            PIN_ADDR:   rdata_s[WIDTH-1:0] = din_o;
            DDR_ADDR:   rdata_s[WIDTH-1:0] = ddr_q;
            PORT_ADDR:  rdata_s[WIDTH-1:0] = port_q;
            PCMSK_ADDR: rdata_s[WIDTH-1:0] = pcmsk_q;
            PCIFR_ADDR: rdata_s[PCIF_BIT]  = pcif_q;
            default:    rd_hit_s = 1'b0;
        endcase
    end

    assign bus.out_en   = bus.iore && rd_hit_s;
    assign bus.dbus_out = bus.out_en ? rdata_s : 8'h00;

    // State registers
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            port_q  <= {WIDTH{1'b0}};
            ddr_q   <= {WIDTH{1'b0}};
            pcmsk_q <= {WIDTH{1'b0}};
            prev_q  <= {WIDTH{1'b0}};
            sync_q  <= {(SYNC_STAGES*WIDTH){1'b0}};
            pcif_q  <= 1'b0;
        end else begin
            port_q  <= port_d;
            ddr_q   <= ddr_d;
            pcmsk_q <= pcmsk_d;
            prev_q  <= din_o;
            sync_q  <= sync_d;
            pcif_q  <= pcif_d;
        end
    end
endmodule

// File: tb/tb_io_port_pcint.sv
// Scoreboard bench for io_port_pcint: a behavioural port model predicts bus reads
// and pad outputs; a negedge monitor pops and compares them.
module tb_io_port_pcint;
    localparam int SS = 2;

    typedef struct {
        int         kind;
        logic [7:0] exp;
    } chk_t;

    logic       cp2 = 1'b0;
    logic       ireset = 1'b1;
    logic [7:0] pin_i = 8'h00;
    logic       PUD = 1'b0, SLEEP = 1'b0, pcie = 1'b0, pcif_ack = 1'b0;
    logic [7:0] ovr_pu_oe = 8'h00, ovr_pu_ov = 8'h00, ovr_dd_oe = 8'h00, ovr_dd_ov = 8'h00;
    logic [7:0] ovr_pv_oe = 8'h00, ovr_pv_ov = 8'h00, ovr_die_oe = 8'h00, ovr_die_ov = 8'h00;
    logic [7:0] pu_n_o, dd_o, pv_o, die_o, din_o;
    logic       pcif, irq;

    int   tests = 0;
    int   fails = 0;
    logic snap = 1'b0;
    logic fin = 1'b0;
    logic [7:0] bus_q[$];
    chk_t       pad_q[$];

    io_port_pcint_if bus();

    io_port_pcint #(.WIDTH(8), .SYNC_STAGES(SS)) dut (
        .cp2(cp2), .ireset(ireset), .bus(bus), .pin_i(pin_i),
        .PUD(PUD), .SLEEP(SLEEP), .pcie(pcie), .pcif_ack(pcif_ack),
        .ovr_pu_oe(ovr_pu_oe), .ovr_pu_ov(ovr_pu_ov), .ovr_dd_oe(ovr_dd_oe), .ovr_dd_ov(ovr_dd_ov),
        .ovr_pv_oe(ovr_pv_oe), .ovr_pv_ov(ovr_pv_ov), .ovr_die_oe(ovr_die_oe), .ovr_die_ov(ovr_die_ov),
        .pu_n_o(pu_n_o), .dd_o(dd_o), .pv_o(pv_o), .die_o(die_o), .din_o(din_o),
        .pcif(pcif), .irq(irq)
    );

    always #5 cp2 = ~cp2;

    // ---------------- reference model ----------------
    logic [7:0] m_port, m_ddr, m_pcmsk, m_prev;
    logic       m_pcif;
    logic [7:0] m_hist[$];   // delay line: m_hist[0] is what the pin register shows

    function automatic void m_reset();
        m_port = 8'h00; m_ddr = 8'h00; m_pcmsk = 8'h00; m_prev = 8'h00; m_pcif = 1'b0;
        m_hist.delete();
        for (int i = 0; i < SS; i++) m_hist.push_back(8'h00);
    endfunction

    function automatic logic [7:0] pick(logic [7:0] oe, logic [7:0] ov, logic [7:0] dflt);
        logic [7:0] r;
        for (int n = 0; n < 8; n++) r[n] = oe[n] ? ov[n] : dflt[n];
        return r;
    endfunction

    function automatic logic [7:0] m_die();
        logic [7:0] d;
        for (int n = 0; n < 8; n++) d[n] = (m_pcmsk[n] && pcie) ? 1'b0 : SLEEP;
        return pick(ovr_die_oe, ovr_die_ov, d);
    endfunction

    function automatic logic [7:0] m_exp(int k);
        logic [7:0] pu;
        for (int n = 0; n < 8; n++) pu[n] = m_port[n] && !m_ddr[n] && !PUD;
        case (k)
            0: return pick(ovr_pv_oe, ovr_pv_ov, m_port);
            1: return pick(ovr_dd_oe, ovr_dd_ov, m_ddr);
            2: return ~pick(ovr_pu_oe, ovr_pu_ov, pu);
            3: return m_die();
            4: return m_hist[0];
            5: return {7'd0, m_pcif};
            6: return {7'd0, m_pcif && pcie};
            default: return 8'h00;
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            0: return "pv_o";
            1: return "dd_o";
            2: return "pu_n_o";
            3: return "die_o";
            4: return "din_o";
            5: return "pcif";
            6: return "irq";
            default: return "bus_idle";
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge cp2) begin
        chk_t       c;
        logic [7:0] a;
        logic [7:0] e;
        if (bus.out_en) begin
            tests++;
            if (bus_q.size() == 0) begin
                fails++;
                $display("FAIL bus_read: out_en with no read pending, dbus_out=%02h", bus.dbus_out);
            end else begin
                e = bus_q.pop_front();
                if (bus.dbus_out !== e) begin
                    fails++;
                    $display("FAIL bus_read addr=%02h: got %02h expected %02h", bus.IO_Addr, bus.dbus_out, e);
                end
            end
        end
        if (snap) begin
            while (pad_q.size() > 0) begin
                c = pad_q.pop_front();
                case (c.kind)
                    0: a = pv_o;
                    1: a = dd_o;
                    2: a = pu_n_o;
                    3: a = die_o;
                    4: a = din_o;
                    5: a = {7'd0, pcif};
                    6: a = {7'd0, irq};
                    default: a = bus.out_en ? 8'hFF : bus.dbus_out;
                endcase
                tests++;
                if (a !== c.exp) begin
                    fails++;
                    $display("FAIL %s: got %02h expected %02h", kname(c.kind), a, c.exp);
                end
            end
        end
        if (fin) begin
            tests++;
            if (bus_q.size() != 0 || pad_q.size() != 0) begin
                fails++;
                $display("FAIL scoreboard_drain: %0d reads and %0d checks left unmatched", bus_q.size(), pad_q.size());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        logic [7:0] qv, chg;
        logic       setf, clrf;
        if (ireset) begin
            m_reset();
        end else begin
            qv   = pin_i & ~m_die();
            chg  = (m_hist[0] ^ m_prev) & m_pcmsk;
            setf = pcie && (chg != 8'h00);
            clrf = pcif_ack || (bus.iowe && bus.IO_Addr == 6'h1B && bus.dbus_in[0]);
            if (bus.iowe) begin
                case (bus.IO_Addr)
                    6'h03: m_port = m_port ^ bus.dbus_in;
                    6'h04: m_ddr = bus.dbus_in;
                    6'h05: m_port = bus.dbus_in;
                    6'h2B: m_pcmsk = bus.dbus_in;
                    default: ;
                endcase
            end
            m_pcif = setf || (m_pcif && !clrf);
            m_prev = m_hist[0];
            m_hist.push_back(qv);
            void'(m_hist.pop_front());
        end
        @(posedge cp2);
        #1;
        snap = 1'b0;
    endtask

    task automatic chk(int k);
        pad_q.push_back('{k, m_exp(k)});
        snap = 1'b1;
    endtask

    task automatic checkpads();
        for (int k = 0; k < 7; k++) chk(k);
    endtask

    task automatic rd(logic [5:0] addr);
        bus.IO_Addr = addr;
        bus.iore = 1'b1;
        case (addr)
            6'h03: bus_q.push_back(m_hist[0]);
            6'h04: bus_q.push_back(m_ddr);
            6'h05: bus_q.push_back(m_port);
            6'h2B: bus_q.push_back(m_pcmsk);
            6'h1B: bus_q.push_back({7'd0, m_pcif});
            default: chk(7);
        endcase
        tick();
        bus.iore = 1'b0;
    endtask

    task automatic wr(logic [5:0] addr, logic [7:0] d);
        bus.IO_Addr = addr;
        bus.dbus_in = d;
        bus.iowe = 1'b1;
        chk(7);
        tick();
        bus.iowe = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [5:0] addrs[6];
        int         op;
        addrs = '{6'h03, 6'h04, 6'h05, 6'h2B, 6'h1B, 6'h10};
        bus.IO_Addr = 6'h00; bus.iore = 1'b0; bus.iowe = 1'b0; bus.dbus_in = 8'h00;
        m_reset();
        idle(2);
        ireset = 1'b0;

        chk(7); checkpads(); tick();
        rd(6'h05); rd(6'h04); rd(6'h2B); rd(6'h03); rd(6'h1B);

        wr(6'h05, 8'hA5); wr(6'h03, 8'h0F); rd(6'h05);
        chk(0); tick();
        wr(6'h04, 8'hF0);
        chk(1); chk(2); tick();
        PUD = 1'b1; chk(2); tick(); PUD = 1'b0;
        wr(6'h04, 8'h00); wr(6'h05, 8'h00);

        pin_i = 8'h08;
        for (int i = 0; i < 3; i++) begin chk(4); tick(); end
        rd(6'h03);
        pin_i = 8'h00; idle(3);
        SLEEP = 1'b1; pin_i = 8'h08;
        for (int i = 0; i < 3; i++) begin chk(3); chk(4); tick(); end
        SLEEP = 1'b0; pin_i = 8'h00; idle(3);

        wr(6'h2B, 8'h08); pcie = 1'b1; pin_i = 8'h08;
        for (int i = 0; i < 4; i++) begin chk(5); chk(6); tick(); end
        wr(6'h1B, 8'h01);
        pin_i = 8'h0C;
        for (int i = 0; i < 4; i++) begin chk(5); tick(); end
        pcie = 1'b0; pin_i = 8'h04;
        for (int i = 0; i < 4; i++) begin chk(5); chk(6); tick(); end
        pcie = 1'b1;
        for (int i = 0; i < 3; i++) begin chk(5); tick(); end

        pin_i = 8'h0C; idle(3);
        chk(5); tick();
        pin_i = 8'h04; idle(2);
        wr(6'h1B, 8'h01);
        chk(5); tick();
        wr(6'h1B, 8'h01);
        chk(5); tick();
        pin_i = 8'h0C; idle(3);
        chk(5); pcif_ack = 1'b1; tick(); pcif_ack = 1'b0;
        chk(5); chk(6); tick();

        wr(6'h04, 8'hFF);
        ovr_dd_oe = 8'hFF; ovr_dd_ov = 8'h00; ovr_pv_oe = 8'h01; ovr_pv_ov = 8'h01;
        checkpads(); tick();
        ovr_dd_oe = 8'h00; ovr_pv_oe = 8'h00; ovr_pv_ov = 8'h00;
        wr(6'h04, 8'h00);

        pin_i = 8'h04; tick();
        ireset = 1'b1; m_reset();
        chk(4); chk(5); tick();
        ireset = 1'b0;
        for (int i = 0; i < 4; i++) begin chk(4); chk(5); tick(); end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) pin_i = 8'($urandom);
            if ($urandom_range(0, 7) == 0) SLEEP = ~SLEEP;
            if ($urandom_range(0, 7) == 0) pcie = ~pcie;
            if ($urandom_range(0, 7) == 0) PUD = ~PUD;
            pcif_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 15) == 0) begin
                ovr_pu_oe  = 8'($urandom) & 8'($urandom); ovr_pu_ov  = 8'($urandom);
                ovr_dd_oe  = 8'($urandom) & 8'($urandom); ovr_dd_ov  = 8'($urandom);
                ovr_pv_oe  = 8'($urandom) & 8'($urandom); ovr_pv_ov  = 8'($urandom);
                ovr_die_oe = 8'($urandom) & 8'($urandom); ovr_die_ov = 8'($urandom);
            end
            checkpads();
            op = $urandom_range(0, 3);
            if (op == 1) begin
                wr(addrs[$urandom_range(0, 5)], 8'($urandom));
            end else if (op == 2) begin
                rd(addrs[$urandom_range(0, 5)]);
            end else begin
                chk(7);
                tick();
            end
            pcif_ack = 1'b0;
        end

        fin = 1'b1;
        tick();
        fin = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
